serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial inverse of the 4-bit ripple adder: given a (WIDTH+1)-bit sum and one WIDTH-bit addend, it recovers the other addend by computing DIFF = SUM_IN − A, one bit per clock, LSB first, through a single full-subtractor cell with a registered borrow. It sits beside the parallel adder on the Basys3 board, so switch-entered results can be checked back against their operands. It also trades area for latency: the datapath is one subtractor cell plus shift registers, driven by a small start/busy/done controller.

## Interface
- WIDTH, 4, operand width; SUM_IN and DIFF are WIDTH+1 bits.
- CLK  input  1  rising-edge system clock.
- RST_N  input  1  asynchronous active-low reset.
- START  input  1  request; sampled only in IDLE.
- SUM_IN  input  WIDTH+1  minuend, captured on the accepting edge.
- A  input  WIDTH  subtrahend, zero-extended to WIDTH+1, captured on the accepting edge.
- DIFF  output  WIDTH+1  registered result, two's-complement wrap of SUM_IN − A.
- BORROW  output  1  final borrow: 1 iff SUM_IN < A (unsigned).
- OVF  output  1  DIFF[WIDTH] & ~BORROW: recovered addend does not fit in WIDTH bits.
- BUSY  output  1  high while in SHIFT.
- DONE  output  1  one-cycle pulse; DIFF, BORROW and OVF are valid from this cycle.

## Operation
- States:
  - IDLE: waits for START.
  - SHIFT: processes one bit per cycle.
  - FIN: one cycle, then returns to IDLE.
- IDLE, START=1 at an edge:
  - Load the minuend shift register with SUM_IN and the subtrahend shift register with {1'b0, A}.
  - Clear the borrow flop and the bit counter (counter width ceil(log2(WIDTH+1)) bits).
  - Go to SHIFT.
- SHIFT, each edge, with s and a the current LSBs and b the borrow flop:
  - d = s^a^b
  - b_next = (~s&a) | (~s&b) | (a&b)
  - Shift d into the MSB of the result shift register; shift both operand registers right; increment the counter.
  - On the edge that processes bit WIDTH (counter == WIDTH): copy the completed result to DIFF, b_next to BORROW, and compute OVF. Go to FIN.
- FIN: DONE=1 for exactly one cycle, then go to IDLE.
- START is ignored in SHIFT and FIN. An operation in flight is never restarted or corrupted.
- DIFF, BORROW and OVF change only on the SHIFT→FIN edge. They hold across IDLE and across the next operation until its completion.
- Operand inputs may change freely after the accepting edge.
- Reset (RST_N low, any time, including mid-SHIFT):
  - Abort immediately and go to IDLE.
  - DIFF=0, BORROW=0, OVF=0, BUSY=0, DONE=0.
  - Shift registers, counter and borrow flop are cleared.
  - After RST_N deasserts, the first START is accepted normally.

## Timing
- START sampled high in IDLE at edge E0.
- BUSY is high after E0 through edge E0+WIDTH+1, i.e. WIDTH+1 cycles (5 for WIDTH=4).
- DIFF, BORROW and OVF update at E0+WIDTH+1, and DONE is high in the following cycle.
- FIN→IDLE at E0+WIDTH+2. The earliest next acceptance is at E0+WIDTH+3. START held high continuously therefore gives one operation every WIDTH+3 cycles.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Reset value of every output is 0.

## Test plan
- Basic: SUM_IN=5'b01001, A=4'b0011, START one cycle → DONE pulses once, 6 cycles after the accepting edge. DIFF=5'b00110, BORROW=0, OVF=0. BUSY was high for exactly 5 cycles.
- Max round-trip: SUM_IN=5'b11110, A=4'b1111 → DIFF=5'b01111, BORROW=0, OVF=0.
- Underflow: SUM_IN=5'b00011, A=4'b0101 → DIFF=5'b11110, BORROW=1, OVF=0.
- Overflow flag: SUM_IN=5'b11111, A=4'b0000 → DIFF=5'b11111, BORROW=0, OVF=1.
- Busy protection: start 9−3, then pulse START with SUM_IN=5'b00001, A=4'b0001 during SHIFT and during FIN → exactly one DONE, DIFF=5'b00110. With START then held high, the next operation is accepted exactly 7 edges after the first acceptance.
- Reset mid-operation: pull RST_N low on the third SHIFT cycle → all outputs 0 immediately and no DONE. After release, 30−15 completes with DIFF=5'b01111.

Source files
------------

// File: rtl/serial_subtractor_if.sv
// ============================================================================
// Module      : serial_subtractor_if
// Description : Request/result bundle for the bit-serial subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface serial_subtractor_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH:0]   sum_in;
    logic [WIDTH-1:0] a;
    logic [WIDTH:0]   diff;
    logic             borrow;
    logic             ovf;
    logic             busy;
    logic             done;

    modport master (
        output start, sum_in, a,
        input  diff, borrow, ovf, busy, done
    );

    modport slave (
        input  start, sum_in, a,
        output diff, borrow, ovf, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/serial_subtractor.sv
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial DIFF = SUM_IN - A, LSB first, one full-subtractor cell.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    serial_subtractor_if.slave  bus
);
    localparam int c_CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIN   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [WIDTH:0]     r_sreg;
    logic [WIDTH:0]     r_areg;
    logic [WIDTH:0]     r_res;
    logic [WIDTH:0]     r_diff;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_b;
    logic               r_borrow;
    logic               r_ovf;

    logic               w_s;
    logic               w_a;
    logic               w_d;
    logic               w_b_nxt;
    logic               w_last;
    logic               w_accept;

    // Single full-subtractor cell on the current LSBs.
    assign w_s      = r_sreg[0];
    assign w_a      = r_areg[0];
    assign w_d      = w_s ^ w_a ^ r_b;
    assign w_b_nxt  = (~w_s & w_a) | (~w_s & r_b) | (w_a & r_b);
    assign w_last   = (r_cnt == c_CNT_W'(WIDTH));
    assign w_accept = (r_state == IDLE) && bus.start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_state_nxt = SHIFT;
            SHIFT:   if (w_last)    w_state_nxt = FIN;
            FIN:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sreg   <= '0;
            r_areg   <= '0;
            r_res    <= '0;
            r_cnt    <= '0;
            r_b      <= 1'b0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_accept) begin
            r_sreg <= bus.sum_in;
            r_areg <= {1'b0, bus.a};
            r_res  <= '0;
            r_cnt  <= '0;
            r_b    <= 1'b0;
        end else if (r_state == SHIFT) begin
            r_sreg <= {1'b0, r_sreg[WIDTH:1]};
            r_areg <= {1'b0, r_areg[WIDTH:1]};
            r_res  <= {w_d, r_res[WIDTH:1]};
            r_cnt  <= r_cnt + 1'b1;
            r_b    <= w_b_nxt;
            // The last bit bypasses r_res so the result lands on this edge.
            if (w_last) begin
                r_diff   <= {w_d, r_res[WIDTH:1]};
                r_borrow <= w_b_nxt;
                r_ovf    <= w_d & ~w_b_nxt;
            end
        end
    end

    assign bus.diff   = r_diff;
    assign bus.borrow = r_borrow;
    assign bus.ovf    = r_ovf;
    assign bus.busy   = (r_state == SHIFT);
    assign bus.done   = (r_state == FIN);

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// ============================================================================
// Module      : tb_serial_subtractor
// Description : Self-checking bench: directed cases plus random operands.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_subtractor;
    localparam int WIDTH = 4;

    logic clk;
    logic rst_n;
    int   r_tests;
    int   r_fails;

    serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        r_tests++;
        if (obs !== exp) begin
            r_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Plain integer arithmetic reference.
    task automatic expect_result(input int s, input int a);
        int d;
        int dw;
        int bw;
        d  = s - a;
        bw = (d < 0) ? 1 : 0;
        dw = (d + 64) % 32;
        check("diff",   32'(bus.diff),   32'(dw));
        check("borrow", 32'(bus.borrow), 32'(bw));
        check("ovf",    32'(bus.ovf),    32'(((dw >= 16) && (bw == 0)) ? 1 : 0));
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_diff"},   32'(bus.diff),   0);
        check({tag, "_borrow"}, 32'(bus.borrow), 0);
        check({tag, "_ovf"},    32'(bus.ovf),    0);
        check({tag, "_busy"},   32'(bus.busy),   0);
        check({tag, "_done"},   32'(bus.done),   0);
    endtask

    // One START pulse, then monitor 10 cycles for BUSY length and DONE timing.
    task automatic run_op(input int s, input int a);
        int busy_cnt;
        int done_cnt;
        int done_at;
        busy_cnt = 0;
        done_cnt = 0;
        done_at  = -1;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.sum_in = 5'(s);
        bus.a      = 4'(a);
        @(negedge clk);
        bus.start  = 1'b0;
        bus.sum_in = 5'($urandom);
        bus.a      = 4'($urandom);
        for (int k = 1; k <= 10; k++) begin
            if (k > 1) @(negedge clk);
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
            end
        end
        check("busy_cycles", 32'(busy_cnt), 5);
        check("done_count",  32'(done_cnt), 1);
        check("done_cycle",  32'(done_at),  6);
        expect_result(s, a);
    endtask

    initial begin
        int bseq;
        int done_cnt;
        r_tests    = 0;
        r_fails    = 0;
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.sum_in = '0;
        bus.a      = '0;
        #1;
        check_outputs_zero("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        run_op(9, 3);
        run_op(30, 15);
        run_op(3, 5);
        run_op(31, 0);
        run_op(0, 15);

        // START pulses during SHIFT and FIN must be ignored.
        done_cnt = 0;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.sum_in = 5'd9;
        bus.a      = 4'd3;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            bus.start  = (k == 2 || k == 6);
            bus.sum_in = 5'd1;
            bus.a      = 4'd1;
            if (bus.done) done_cnt++;
        end
        check("prot_done_count", 32'(done_cnt), 1);
        check("prot_diff",       32'(bus.diff), 32'd6);

        // START held high: second acceptance 7 edges after the first.
        bseq = 0;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.sum_in = 5'd9;
        bus.a      = 4'd3;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (bus.busy) bseq = bseq | (1 << (k - 1));
        end
        bus.start = 1'b0;
        check("held_busy_seq", 32'(bseq), 32'h9F);
        done_cnt = 0;
        for (int k = 0; k < 10 && done_cnt == 0; k++) begin
            @(negedge clk);
            if (bus.done) done_cnt++;
        end
        check("held_second_done", 32'(done_cnt), 1);
        expect_result(9, 3);

        // Reset on the third SHIFT cycle.
        @(negedge clk);
        bus.start  = 1'b1;
        bus.sum_in = 5'd20;
        bus.a      = 4'd1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_reset_busy", 32'(bus.busy), 1);
        #1 rst_n = 1'b0;
        #1;
        check_outputs_zero("midrst");
        @(negedge clk);
        rst_n    = 1'b1;
        done_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.done || bus.busy) done_cnt++;
        end
        check("post_reset_idle", 32'(done_cnt), 0);
        run_op(30, 15);

        for (int i = 0; i < 40; i++) begin
            run_op(int'($urandom_range(31, 0)), int'($urandom_range(15, 0)));
        end

        $display("[TB] %0d tests run, %0d failed", r_tests, r_fails);
        $finish;
    end

endmodule

`default_nettype wire
